int_vector_ctrl: RTL

- Parametrised, prioritised interrupt controller that drives the CPU's NMI, INT, IntAddrLSBs and INTACK interface.
- Takes NUM_CH maskable peripheral sources plus one non-maskable source.
- Synchronises and latches requests, then arbitrates by fixed priority.
- Presents a vector that stays stable across the CPU acknowledge, and returns per-channel acknowledge pulses to peripherals.

---
 rtl/int_vector_ctrl.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/int_vector_ctrl.sv
// int_vector_ctrl: prioritised interrupt controller for the CPU NMI/INT/
// IntAddrLSBs/INTACK interface. It synchronises the raw requests and latches
// them as pending flags. NMI wins, then the lowest-numbered enabled channel.
// The selected vector is frozen while the CPU acknowledges, and a one-hot
// acknowledge pulse goes back to the serviced peripheral.
module int_vector_ctrl #(
    parameter int                NUM_CH    = 16,
    parameter logic [NUM_CH-1:0] EDGE_MASK = {NUM_CH{1'b1}},
    parameter logic [5:0]        NMI_LSB   = 6'd62
) (
    input  logic              MCLK,
    input  logic              reset,
    input  logic [NUM_CH-1:0] irq,
    input  logic [NUM_CH-1:0] ie,
    input  logic              nmi_in,
    input  logic [NUM_CH-1:0] clr,
    input  logic              INTACK,
    output logic              NMI,
    output logic              INT,
    output logic [5:0]        IntAddrLSBs,
    output logic              ack_valid,
    output logic [NUM_CH-1:0] ack_ch,
    output logic [NUM_CH-1:0] pending
);

    localparam int NMI_LSB_I = int'(NMI_LSB);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // Synchroniser chains. The third stage exists only for edge detection.
    logic [NUM_CH-1:0] r_irq_s1, r_irq_s2, r_irq_s3;
    logic              r_nmi_s1, r_nmi_s2, r_nmi_s3;

    // Pending flags.
    logic [NUM_CH-1:0] r_pending;
    logic              r_nmi_pend;

    // State and registered CPU-facing outputs.
    state_t            r_state, w_state_nxt;
    logic              r_nmi_out, w_nmi_out_nxt;
    logic              r_int_out, w_int_out_nxt;
    logic [5:0]        r_vec, w_vec_nxt;

    // Vector currently presented. A one-hot channel of 0 means NMI or none.
    logic [NUM_CH-1:0] r_lock_oh, w_lock_oh_nxt;
    logic              r_lock_nmi, w_lock_nmi_nxt;

    // Combinational helpers.
    logic [NUM_CH-1:0] w_irq_rise;
    logic              w_nmi_rise;
    logic [NUM_CH-1:0] w_ack_clr;
    logic              w_nmi_ack_clr;
    logic [NUM_CH-1:0] w_edge_nxt;
    logic [NUM_CH-1:0] w_pend_nxt;
    logic [NUM_CH-1:0] w_cand;
    logic [NUM_CH-1:0] w_arb_oh;
    logic [5:0]        w_arb_vec;
    logic              w_arb_found;
    logic              w_req_any;

    assign w_irq_rise    = r_irq_s2 & ~r_irq_s3;
    assign w_nmi_rise    = r_nmi_s2 & ~r_nmi_s3;
    assign w_ack_clr     = (r_state == ST_ACK && !r_lock_nmi) ? r_lock_oh : '0;
    assign w_nmi_ack_clr = (r_state == ST_ACK) && r_lock_nmi;

    // Set has priority over clr or acknowledge, so a new edge is never lost.
    // Level channels simply follow the synchronised input.
    assign w_edge_nxt = w_irq_rise | (r_pending & ~clr & ~w_ack_clr);
    assign w_pend_nxt = (EDGE_MASK & w_edge_nxt) | (~EDGE_MASK & r_irq_s2);

    assign w_cand    = r_pending & ie;
    assign w_req_any = r_nmi_pend | (|w_cand);

    // Two-flop synchronisers plus one edge-detect stage for irq and nmi_in.
    always_ff @(posedge MCLK) begin
        // NOTE: the reset is synchronous and active-high. It is sampled only
        // on MCLK edges, so it never appears in the sensitivity list.
        if (reset) begin
            r_irq_s1 <= '0;
            r_irq_s2 <= '0;
            r_irq_s3 <= '0;
            r_nmi_s1 <= 1'b0;
            r_nmi_s2 <= 1'b0;
            r_nmi_s3 <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every stage sample the old
            // value of the stage before it. Blocking assignments would
            // collapse the chain into a single flop.
            r_irq_s1 <= irq;
            r_irq_s2 <= r_irq_s1;
            r_irq_s3 <= r_irq_s2;
            r_nmi_s1 <= nmi_in;
            r_nmi_s2 <= r_nmi_s1;
            r_nmi_s3 <= r_nmi_s2;
        end
    end

    // Pending flags: edge channels latch rising edges; the NMI flag is
    // cleared only by its own acknowledge.
    always_ff @(posedge MCLK) begin
        if (reset) begin
            r_pending  <= '0;
            r_nmi_pend <= 1'b0;
        end else begin
            r_pending  <= w_pend_nxt;
            r_nmi_pend <= w_nmi_rise | (r_nmi_pend & ~w_nmi_ack_clr);
        end
    end

    // Fixed-priority search: the lowest enabled pending channel wins.
    always_comb begin
        // NOTE: give every variable a default first so that no path leaves it
        // unassigned. An unassigned path would infer a latch.
        w_arb_oh    = '0;
        w_arb_vec   = '0;
        w_arb_found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_cand[i] && !w_arb_found) begin
                w_arb_found = 1'b1;
                w_arb_oh[i] = 1'b1;
                w_arb_vec   = 6'(NMI_LSB_I - 1 - i);
            end
        end
    end

    // State, presented vector and lock registers.
    always_ff @(posedge MCLK) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_nmi_out  <= 1'b0;
            r_int_out  <= 1'b0;
            r_vec      <= '0;
            r_lock_oh  <= '0;
            r_lock_nmi <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_nmi_out  <= w_nmi_out_nxt;
            r_int_out  <= w_int_out_nxt;
            r_vec      <= w_vec_nxt;
            r_lock_oh  <= w_lock_oh_nxt;
            r_lock_nmi <= w_lock_nmi_nxt;
        end
    end

    // Next-state logic: arbitrate in IDLE/REQ, freeze on INTACK, hold until
    // INTACK drops.
    always_comb begin
        w_state_nxt    = r_state;
        w_nmi_out_nxt  = r_nmi_out;
        w_int_out_nxt  = r_int_out;
        w_vec_nxt      = r_vec;
        w_lock_oh_nxt  = r_lock_oh;
        w_lock_nmi_nxt = r_lock_nmi;

        unique case (r_state)
            ST_IDLE: begin
                w_nmi_out_nxt = 1'b0;
                w_int_out_nxt = 1'b0;
                // A stray INTACK in IDLE must not lead to an acknowledge, so
                // a request is raised only while INTACK is low.
                if (w_req_any && !INTACK) begin
                    w_state_nxt    = ST_REQ;
                    w_nmi_out_nxt  = r_nmi_pend;
                    w_int_out_nxt  = !r_nmi_pend;
                    w_vec_nxt      = r_nmi_pend ? NMI_LSB : w_arb_vec;
                    w_lock_oh_nxt  = r_nmi_pend ? '0 : w_arb_oh;
                    w_lock_nmi_nxt = r_nmi_pend;
                end
            end
            ST_REQ: begin
                if (INTACK) begin
                    // Freeze the vector the CPU is fetching.
                    w_state_nxt = ST_ACK;
                end else if (w_req_any) begin
                    w_nmi_out_nxt  = r_nmi_pend;
                    w_int_out_nxt  = !r_nmi_pend;
                    w_vec_nxt      = r_nmi_pend ? NMI_LSB : w_arb_vec;
                    w_lock_oh_nxt  = r_nmi_pend ? '0 : w_arb_oh;
                    w_lock_nmi_nxt = r_nmi_pend;
                end else begin
                    w_state_nxt    = ST_IDLE;
                    w_nmi_out_nxt  = 1'b0;
                    w_int_out_nxt  = 1'b0;
                    w_vec_nxt      = '0;
                    w_lock_oh_nxt  = '0;
                    w_lock_nmi_nxt = 1'b0;
                end
            end
            ST_ACK: begin
                w_state_nxt   = ST_HOLD;
                w_nmi_out_nxt = 1'b0;
                w_int_out_nxt = 1'b0;
            end
            ST_HOLD: begin
                w_nmi_out_nxt = 1'b0;
                w_int_out_nxt = 1'b0;
                if (!INTACK) begin
                    w_state_nxt    = ST_IDLE;
                    w_vec_nxt      = '0;
                    w_lock_oh_nxt  = '0;
                    w_lock_nmi_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign NMI         = r_nmi_out;
    assign INT         = r_int_out;
    assign IntAddrLSBs = r_vec;
    assign ack_valid   = (r_state == ST_ACK);
    assign ack_ch      = ack_valid ? r_lock_oh : '0;
    assign pending     = r_pending;

endmodule
